// File: rtl/traffic_light_sequencer.sv
// Main/side road traffic-light sequencer driven by a 1 Hz enable tick.
// Counts whole seconds per phase, latches side-road vehicle and pedestrian
// requests, and restarts the seconds divider on every phase change.
module traffic_light_sequencer #(
    parameter int T_BASE   = 10,
    parameter int T_YEL    = 3,
    parameter int T_ALLRED = 1,
    parameter int T_SIDE   = 5,
    parameter int T_WALK   = 8,
    parameter int T_EXT    = 4,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       global_reset,
    input  logic       enable_1Hz,
    input  logic       sensor,
    input  logic       walk_request,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_light,
    output logic       divider_reset,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_YEL = 3'd1,
        ALLRED1  = 3'd2,
        SIDE_GRN = 3'd3,
        SIDE_YEL = 3'd4,
        ALLRED2  = 3'd5
    } state_e;

    // Lamp encodings, {red,yellow,green}
    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    localparam logic [CNT_W-1:0] L_BASE   = CNT_W'(T_BASE);
    localparam logic [CNT_W-1:0] L_YEL    = CNT_W'(T_YEL);
    localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED);
    localparam logic [CNT_W-1:0] L_SIDE   = CNT_W'(T_SIDE);
    localparam logic [CNT_W-1:0] L_WALK   = CNT_W'(T_WALK);
    localparam logic [CNT_W-1:0] L_EXT    = CNT_W'(T_EXT);
    localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             sensor_pend_q, sensor_pend_d;
    logic             walk_pend_q, walk_pend_d;
    logic             ext_used_q, ext_used_d;
    logic             walk_served_q, walk_served_d;
    logic [2:0]       main_light_q, main_light_d;
    logic [2:0]       side_light_q, side_light_d;
    logic             walk_light_q, walk_light_d;
    logic             divider_reset_q, divider_reset_d;

    logic             tick;
    logic             expire;
    logic             illegal;

    // Next-state, timer, request latches and registered lamp decode
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        sensor_pend_d = sensor_pend_q | sensor;
        walk_pend_d   = walk_pend_q | walk_request;
        ext_used_d    = ext_used_q;
        walk_served_d = walk_served_q;
        illegal       = 1'b0;

        // A tick landing on the divider restart cycle belongs to no phase
        tick   = enable_1Hz && !divider_reset_q;
        expire = tick && (timer_q == L_ONE);

        // Decrement stops at 1; expiry or the MAIN_GRN hold handles the rest
        if (tick && (timer_q > L_ONE)) begin
            timer_d = timer_q - L_ONE;
        end

        case (state_q)
            MAIN_GRN: begin
                if (expire && (sensor_pend_d || walk_pend_d)) begin
                    state_d = MAIN_YEL;
                    timer_d = L_YEL;
                end
            end
            MAIN_YEL: begin
                if (expire) begin
                    state_d = ALLRED1;
                    timer_d = L_ALLRED;
                end
            end
            ALLRED1: begin
                if (expire) begin
                    state_d       = SIDE_GRN;
                    timer_d       = walk_pend_d ? L_WALK : L_SIDE;
                    walk_served_d = walk_pend_d;
                    // Requests seen on the entry edge are intentionally dropped
                    sensor_pend_d = 1'b0;
                    walk_pend_d   = 1'b0;
                end
            end
            SIDE_GRN: begin
                if (expire) begin
                    if (sensor && !ext_used_q) begin
                        timer_d    = L_EXT;
                        ext_used_d = 1'b1;
                    end else begin
                        state_d = SIDE_YEL;
                        timer_d = L_YEL;
                    end
                end
            end
            SIDE_YEL: begin
                if (expire) begin
                    state_d = ALLRED2;
                    timer_d = L_ALLRED;
                end
            end
            ALLRED2: begin
                if (expire) begin
                    state_d       = MAIN_GRN;
                    timer_d       = L_BASE;
                    ext_used_d    = 1'b0;
                    walk_served_d = 1'b0;
                end
            end
            default: begin
                // Codes 6/7: recover exactly as from reset, no divider pulse
                illegal       = 1'b1;
                state_d       = MAIN_GRN;
                timer_d       = L_BASE;
                sensor_pend_d = 1'b0;
                walk_pend_d   = 1'b0;
                ext_used_d    = 1'b0;
                walk_served_d = 1'b0;
            end
        endcase

        // Extension reload keeps the state, so it never restarts the divider
        divider_reset_d = (state_d != state_q) && !illegal;

        case (state_d)
            MAIN_GRN: begin main_light_d = LAMP_G; side_light_d = LAMP_R; end
            MAIN_YEL: begin main_light_d = LAMP_Y; side_light_d = LAMP_R; end
            SIDE_GRN: begin main_light_d = LAMP_R; side_light_d = LAMP_G; end
            SIDE_YEL: begin main_light_d = LAMP_R; side_light_d = LAMP_Y; end
            ALLRED1, ALLRED2: begin main_light_d = LAMP_R; side_light_d = LAMP_R; end
            default: begin main_light_d = LAMP_G; side_light_d = LAMP_R; end
        endcase

        walk_light_d = (state_d == SIDE_GRN) && walk_served_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_q         <= MAIN_GRN;
            timer_q         <= L_BASE;
            sensor_pend_q   <= 1'b0;
            walk_pend_q     <= 1'b0;
            ext_used_q      <= 1'b0;
            walk_served_q   <= 1'b0;
            main_light_q    <= LAMP_G;
            side_light_q    <= LAMP_R;
            walk_light_q    <= 1'b0;
            divider_reset_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            sensor_pend_q   <= sensor_pend_d;
            walk_pend_q     <= walk_pend_d;
            ext_used_q      <= ext_used_d;
            walk_served_q   <= walk_served_d;
            main_light_q    <= main_light_d;
            side_light_q    <= side_light_d;
            walk_light_q    <= walk_light_d;
            divider_reset_q <= divider_reset_d;
        end
    end

    assign main_light    = main_light_q;
    assign side_light    = side_light_q;
    assign walk_light    = walk_light_q;
    assign divider_reset = divider_reset_q;
    assign phase         = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench for traffic_light_sequencer: stimulus queues expected
// phase entries and state snapshots; the monitor pops and compares them.
module tb_traffic_light_sequencer;

    logic       clk = 1'b0;
    logic       global_reset = 1'b0;
    logic       enable_1Hz = 1'b0;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic [2:0] main_light, side_light, phase;
    logic       walk_light, divider_reset;

    logic       sensor_hold = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         ticks = 0;

    typedef struct {
        string      name;
        logic [2:0] ph;
        logic       walk;
        int         len;
    } entry_t;

    typedef struct {
        string      name;
        bit         full;
        logic [2:0] ph;
        logic       walk;
        logic       dr;
        logic [4:0] timer;
        logic       sp, wp, ext, ws;
    } snap_t;

    entry_t exp_q[$];
    snap_t  snap_q[$];

    traffic_light_sequencer #(
        .T_BASE(3), .T_YEL(2), .T_ALLRED(1), .T_SIDE(2),
        .T_WALK(4), .T_EXT(2), .CNT_W(5)
    ) dut (
        .clk(clk),
        .global_reset(global_reset),
        .enable_1Hz(enable_1Hz),
        .sensor(sensor),
        .walk_request(walk_request),
        .main_light(main_light),
        .side_light(side_light),
        .walk_light(walk_light),
        .divider_reset(divider_reset),
        .phase(phase)
    );

    always #5 clk = ~clk;

    // Lamp table {main,side} for each phase code
    function automatic logic [5:0] lamps_of(input logic [2:0] ph);
        case (ph)
            3'd0:       lamps_of = {3'b001, 3'b100};
            3'd1:       lamps_of = {3'b010, 3'b100};
            3'd2, 3'd5: lamps_of = {3'b100, 3'b100};
            3'd3:       lamps_of = {3'b100, 3'b001};
            3'd4:       lamps_of = {3'b100, 3'b010};
            default:    lamps_of = {3'b001, 3'b100};
        endcase
    endfunction

    task automatic push_entry(input string name, input logic [2:0] ph,
                              input logic walk, input int len);
        entry_t e;
        e.name = name; e.ph = ph; e.walk = walk; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic push_snap(input string name, input bit full, input logic [2:0] ph,
                             input logic walk, input logic dr, input logic [4:0] timer,
                             input logic sp, input logic wp, input logic ext, input logic ws);
        snap_t s;
        s.name = name; s.full = full; s.ph = ph; s.walk = walk; s.dr = dr;
        s.timer = timer; s.sp = sp; s.wp = wp; s.ext = ext; s.ws = ws;
        snap_q.push_back(s);
    endtask

    // Monitor: count effective ticks per phase, check entries and snapshots
    always begin : monitor
        entry_t e;
        snap_t  s;
        bit     ok;
        @(posedge clk);
        if (global_reset) ticks = 0;
        else if (enable_1Hz && !divider_reset) ticks++;
        @(negedge clk);
        #2;
        if (divider_reset === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_phase_change: got phase=%0d len=%0d, want no divider_reset",
                         phase, ticks);
            end else begin
                e = exp_q.pop_front();
                if (phase !== e.ph || {main_light, side_light} !== lamps_of(e.ph) ||
                    walk_light !== e.walk || ticks != e.len) begin
                    errors++;
                    $display("FAIL %s: got phase=%0d main=%b side=%b walk=%b prev_len=%0d, want phase=%0d lamps=%b walk=%b prev_len=%0d",
                             e.name, phase, main_light, side_light, walk_light, ticks,
                             e.ph, lamps_of(e.ph), e.walk, e.len);
                end
            end
            ticks = 0;
        end
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            checks++;
            ok = (phase === s.ph) && ({main_light, side_light} === lamps_of(s.ph)) &&
                 (walk_light === s.walk) && (divider_reset === s.dr);
            if (s.full)
                ok = ok && (dut.timer_q === s.timer) && (dut.sensor_pend_q === s.sp) &&
                     (dut.walk_pend_q === s.wp) && (dut.ext_used_q === s.ext) &&
                     (dut.walk_served_q === s.ws);
            if (!ok) begin
                errors++;
                $display("FAIL %s: got ph=%0d main=%b side=%b walk=%b dr=%b timer=%0d sp=%b wp=%b ext=%b ws=%b, want ph=%0d lamps=%b walk=%b dr=%b timer=%0d sp=%b wp=%b ext=%b ws=%b (full=%0d)",
                         s.name, phase, main_light, side_light, walk_light, divider_reset,
                         dut.timer_q, dut.sensor_pend_q, dut.walk_pend_q, dut.ext_used_q,
                         dut.walk_served_q, s.ph, lamps_of(s.ph), s.walk, s.dr, s.timer,
                         s.sp, s.wp, s.ext, s.ws, s.full);
            end
        end
    end

    // Watchdog bound on the whole run
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 20000 cycles, want completion");
        $fatal(1, "watchdog");
    end

    // One 10-clk tick slot: pre cycle, tick cycle, 8 idle cycles
    task automatic do_tick(input logic s_pre, input logic w_pre,
                           input logic s_tk, input logic w_tk);
        sensor = s_pre | sensor_hold; walk_request = w_pre;
        @(negedge clk);
        enable_1Hz = 1'b1; sensor = s_tk | sensor_hold; walk_request = w_tk;
        @(negedge clk);
        enable_1Hz = 1'b0; sensor = sensor_hold; walk_request = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic plain_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        global_reset = 1'b1; enable_1Hz = 1'b0; sensor = 1'b0;
        walk_request = 1'b0; sensor_hold = 1'b0;
        repeat (2) @(negedge clk);
        push_snap("reset_state", 1, 3'd0, 0, 0, 5'd3, 0, 0, 0, 0);
        global_reset = 1'b0;
    endtask

    initial begin
        // 1: no requests, MAIN_GRN holds with timer parked at 1
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_tick(1'b0, 1'b0, 1'b0, 1'b0);
            push_snap("idle_main_grn", 0, 3'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        end
        push_snap("idle_timer_held", 1, 3'd0, 0, 0, 5'd1, 0, 0, 0, 0);

        // 2: sensor pulse before 3rd tick, full cycle 3,2,1,2,2,1
        do_reset();
        push_entry("s2_main_yel", 3'd1, 0, 3);
        push_entry("s2_allred1",  3'd2, 0, 2);
        push_entry("s2_side_grn", 3'd3, 0, 1);
        push_entry("s2_side_yel", 3'd4, 0, 2);
        push_entry("s2_allred2",  3'd5, 0, 2);
        push_entry("s2_main_grn", 3'd0, 0, 1);
        plain_ticks(2);
        do_tick(1'b1, 1'b0, 1'b0, 1'b0);
        plain_ticks(3);
        push_snap("s2_side_grn_nowalk", 0, 3'd3, 0, 0, 5'd0, 0, 0, 0, 0);
        plain_ticks(5);

        // 3: walk request -> 4-tick SIDE_GRN with walk lamp
        push_entry("s3_main_yel", 3'd1, 0, 3);
        push_entry("s3_allred1",  3'd2, 0, 2);
        push_entry("s3_side_grn", 3'd3, 1, 1);
        push_entry("s3_side_yel", 3'd4, 0, 4);
        push_entry("s3_allred2",  3'd5, 0, 2);
        push_entry("s3_main_grn", 3'd0, 0, 1);
        do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        plain_ticks(5);
        push_snap("s3_walk_entry", 1, 3'd3, 1, 0, 5'd4, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            do_tick(1'b0, 1'b0, 1'b0, 1'b0);
            push_snap("s3_walk_held", 0, 3'd3, 1, 0, 5'd0, 0, 0, 0, 0);
        end
        do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        push_snap("s3_walk_off_side_yel", 0, 3'd4, 0, 0, 5'd0, 0, 0, 0, 0);
        plain_ticks(3);

        // 4: sensor held -> one extension, SIDE_GRN lasts 2+2
        push_entry("s4_main_yel", 3'd1, 0, 3);
        push_entry("s4_allred1",  3'd2, 0, 2);
        push_entry("s4_side_grn", 3'd3, 0, 1);
        push_entry("s4_side_yel", 3'd4, 0, 4);
        push_entry("s4_allred2",  3'd5, 0, 2);
        push_entry("s4_main_grn", 3'd0, 0, 1);
        sensor_hold = 1'b1; sensor = 1'b1;
        plain_ticks(8);
        push_snap("s4_extension", 1, 3'd3, 0, 0, 5'd2, 1, 0, 1, 0);
        plain_ticks(2);
        sensor_hold = 1'b0; sensor = 1'b0;
        plain_ticks(3);
        push_snap("s4_ext_cleared", 1, 3'd0, 0, 0, 5'd3, 1, 0, 0, 0);

        // 5: reset in SIDE_YEL coincident with a tick
        push_entry("s5_main_yel", 3'd1, 0, 3);
        push_entry("s5_allred1",  3'd2, 0, 2);
        push_entry("s5_side_grn", 3'd3, 0, 1);
        push_entry("s5_side_yel", 3'd4, 0, 2);
        plain_ticks(8);
        walk_request = 1'b1;
        @(negedge clk);
        walk_request = 1'b0; enable_1Hz = 1'b1; global_reset = 1'b1;
        @(negedge clk);
        push_snap("s5_reset_in_side_yel", 1, 3'd0, 0, 0, 5'd3, 0, 0, 0, 0);
        enable_1Hz = 1'b0; global_reset = 1'b0;
        repeat (8) @(negedge clk);

        // 6: request on the expiring tick; tick during divider_reset ignored
        push_entry("s6_main_yel", 3'd1, 0, 3);
        push_entry("s6_allred1",  3'd2, 0, 2);
        push_entry("s6_side_grn", 3'd3, 0, 1);
        plain_ticks(2);
        enable_1Hz = 1'b1; sensor = 1'b1;
        @(negedge clk);
        push_snap("s6_same_cycle_request", 1, 3'd1, 0, 1, 5'd2, 1, 0, 0, 0);
        sensor = 1'b0;
        @(negedge clk);
        push_snap("s6_tick_on_divider_reset", 1, 3'd1, 0, 0, 5'd2, 1, 0, 0, 0);
        enable_1Hz = 1'b0;
        repeat (8) @(negedge clk);
        plain_ticks(3);

        repeat (2) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0 || snap_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got %0d entries %0d snapshots left, want 0 0",
                     exp_q.size(), snap_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
